wired_iq_dispatch: RTL and testbench
====================================

Name: wired_iq_dispatch

Overview:
- Issue queue directly downstream of the rename stage. Receives the renamed dual-instruction packet at the P (dispatch) stage and holds each instruction until both source operands are available.
- Operands become available either at dispatch (from ARF/ROB read) or later by snooping CDB broadcasts.
- Issues one ready instruction per cycle, oldest first, to an execution unit.

Parameters:
- DEPTH, 8, number of queue entries; must be >= 2.
- ROB_ID_W, 6, width of a ROB register id.
- DATA_W, 32, operand width.
- PAYLOAD_W, 96, opaque per-instruction control payload (decode info, wreg, pc).
- CDB_N, 2, number of CDB broadcast ports.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush_i  in  1  pipeline flush from commit
- p_valid_i  in  1  dispatch packet valid
- p_ready_o  out  1  queue can accept a full 2-wide packet
- p_mask_i  in  2  per-slot valid; slot 0 is older than slot 1
- p_payload_i  in  2xPAYLOAD_W  per-slot payload
- p_src_rid_i  in  2x2xROB_ID_W  per-slot, per-source ROB id
- p_src_rdy_i  in  2x2  source already valid at dispatch
- p_src_data_i  in  2x2xDATA_W  source data, meaningful when rdy=1
- cdb_valid_i  in  CDB_N  broadcast valid
- cdb_rid_i  in  CDB_NxROB_ID_W  broadcast ROB id
- cdb_data_i  in  CDB_NxDATA_W  broadcast data
- e_valid_o  out  1  an issued instruction is presented
- e_ready_i  in  1  execution unit accepts
- e_payload_o  out  PAYLOAD_W  issued payload
- e_src_data_o  out  2xDATA_W  issued operands

Behaviour:
Reset and flush:
- Reset: all entries invalid, count=0, e_valid_o=0, p_ready_o=1.
- Entry state: valid, payload, src_rdy[2], src_rid[2], src_data[2]. Entries are kept age-ordered, compacting; index 0 is the oldest.
- flush_i: all entries invalid next cycle and count=0. Dispatch and issue handshakes in the flush cycle have no effect on state. e_valid_o is forced 0 in the flush cycle.

Dispatch:
- p_ready_o = (DEPTH - count) >= 2, computed from the registered count only. It must not depend on same-cycle issue or on p_valid_i.
- Accept when p_valid_i && p_ready_o && !flush_i. Slots with a set mask bit are appended at the tail in slot order. Mask 2'b10 places slot 1 at the tail. Mask 2'b00 is a no-op.
- Same-cycle CDB bypass at dispatch: if a source has rdy=0 and matches a valid cdb_rid_i in that cycle, it is stored ready with the CDB data.

Wakeup:
- Each cycle, every valid entry with src_rdy=0 compares src_rid against all CDB ports. On a match it sets src_rdy and latches the data.
- A broadcast in cycle t makes the entry issue-eligible in cycle t+1 at the earliest.
- If multiple ports match, the lowest port index wins.
- Already-ready sources ignore the CDB.

Issue:
- Select is combinational: e_valid_o=1 iff some valid entry has both src_rdy set. The lowest index (oldest) such entry drives e_payload_o and e_src_data_o.
- On e_valid_o && e_ready_i the entry is removed at the clock edge and younger entries shift down one.
- Outputs must hold stable while e_valid_o && !e_ready_i, unless flush_i is asserted.

Simultaneous events and count:
- Issue and dispatch in the same cycle: removal and compaction happen first, then new entries append. count_next = count - issued + accepted.
- Wakeup in the same cycle as compaction applies to the entry at its new index.
- count saturates logically at DEPTH. Dispatch into a full queue is impossible because p_ready_o gates it.

Decomposition:
- Package (wired0_defines.svh): typedefs iq_src_t {rdy, rid, data} and iq_entry_t {valid, payload, src[2]}, plus the CDB port struct cdb_t {valid, rid, data}.
- Sub-module wired_iq_entry: one entry's storage, CDB comparison/wakeup logic and shift-in mux; instantiated DEPTH times.
- The top level holds count, the oldest-ready priority select and compaction control.

Test Plan:
- Reset, then dispatch mask=2'b11 with all sources rdy=1 (data 0x11,0x22 / 0x33,0x44) and e_ready_i=1 → slot 0 issues next cycle with data 0x11/0x22, slot 1 issues the cycle after with 0x33/0x44.
- Dispatch one entry with src0 rid=5 not ready → e_valid_o stays 0. CDB port 1 broadcasts rid=5, data 0xDEADBEEF at cycle t → e_valid_o=1 at t+1 with e_src_data_o[0]=0xDEADBEEF.
- Fill DEPTH=8 entries with unready sources → p_ready_o=0 at count 7 and count 8. Wake and issue one entry → p_ready_o returns 1 only when count ≤ 6.
- Entries A (older, unready) and B (younger, ready) → B issues first. Wake A → A issues next; order of removal is preserved under compaction.
- CDB broadcast of rid=9 in the same cycle a source with rid=9 is dispatched not ready → entry is issue-eligible the following cycle with the bypassed data.
- Hold e_ready_i=0 with 3 ready entries, then pulse flush_i → e_valid_o=0 next cycle, count=0, p_ready_o=1. A dispatch in the flush cycle is not enqueued.

Source files
------------

// File: rtl/wired_iq_dispatch_pkg.sv
// Shared types for the dispatch-stage issue queue: entry layout, CDB port and
// per-entry next-value select codes.
package wired_iq_dispatch_pkg;

  localparam int unsigned ROB_ID_W  = 6;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PAYLOAD_W = 96;
  localparam int unsigned NSRC      = 2;
  localparam int unsigned NSLOT     = 2;

  typedef struct packed {
    logic                rdy;
    logic [ROB_ID_W-1:0] rid;
    logic [DATA_W-1:0]   data;
  } iq_src_t;

  typedef struct packed {
    logic                 valid;
    logic [PAYLOAD_W-1:0] payload;
    iq_src_t [NSRC-1:0]   src;
  } iq_entry_t;

  typedef struct packed {
    logic                valid;
    logic [ROB_ID_W-1:0] rid;
    logic [DATA_W-1:0]   data;
  } cdb_t;

  // Where an entry takes its next value from before wakeup is applied.
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SHIFT,
    SEL_LOAD0,
    SEL_LOAD1,
    SEL_CLEAR
  } iq_sel_e;

endpackage

// File: rtl/wired_iq_entry.sv
// One issue-queue entry: shift-in/load mux followed by CDB wakeup, so a source
// is woken at whatever index the entry lands on this cycle.
module wired_iq_entry
  import wired_iq_dispatch_pkg::*;
#(
  parameter int unsigned CDB_N = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  iq_sel_e               sel,
  input  iq_entry_t             shift_in,
  input  iq_entry_t             load0,
  input  iq_entry_t             load1,
  input  cdb_t [CDB_N-1:0]      cdb,
  output iq_entry_t             entry,
  output logic                  ready_c
);

  iq_entry_t base;
  iq_entry_t nxt;

  always_comb begin
    base = entry;
    case (sel)
      SEL_SHIFT: base = shift_in;
      SEL_LOAD0: base = load0;
      SEL_LOAD1: base = load1;
      SEL_CLEAR: base = '0;
      default:   base = entry;
    endcase
    nxt = base;
    // Scan ports high to low so the lowest matching port index wins.
    for (int s = 0; s < int'(NSRC); s++) begin
      for (int p = int'(CDB_N) - 1; p >= 0; p--) begin
        if (base.valid && !base.src[s].rdy && cdb[p].valid &&
            (cdb[p].rid == base.src[s].rid)) begin
          nxt.src[s].rdy  = 1'b1;
          nxt.src[s].data = cdb[p].data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) entry <= '0;
    else                 entry <= nxt;
  end

  assign ready_c = entry.valid & entry.src[0].rdy & entry.src[1].rdy;

endmodule

// File: rtl/wired_iq_dispatch.sv
// Age-ordered compacting issue queue: accepts a 2-wide renamed packet, wakes
// sources from the CDB and issues the oldest fully ready entry each cycle.
module wired_iq_dispatch
  import wired_iq_dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CDB_N = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush_i,
  input  logic                                  p_valid_i,
  output logic                                  p_ready_o,
  input  logic [NSLOT-1:0]                      p_mask_i,
  input  logic [NSLOT-1:0][PAYLOAD_W-1:0]       p_payload_i,
  input  logic [NSLOT-1:0][NSRC-1:0][ROB_ID_W-1:0] p_src_rid_i,
  input  logic [NSLOT-1:0][NSRC-1:0]            p_src_rdy_i,
  input  logic [NSLOT-1:0][NSRC-1:0][DATA_W-1:0] p_src_data_i,
  input  logic [CDB_N-1:0]                      cdb_valid_i,
  input  logic [CDB_N-1:0][ROB_ID_W-1:0]        cdb_rid_i,
  input  logic [CDB_N-1:0][DATA_W-1:0]          cdb_data_i,
  output logic                                  e_valid_o,
  input  logic                                  e_ready_i,
  output logic [PAYLOAD_W-1:0]                  e_payload_o,
  output logic [NSRC-1:0][DATA_W-1:0]           e_src_data_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] base_cnt;
  logic             lock_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic [IDX_W-1:0] prio_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [DEPTH-1:0] ready_c;
  logic             issue;
  logic             accept;
  logic [1:0]       n_acc;

  iq_entry_t        entries   [DEPTH];
  iq_entry_t        shift_src [DEPTH];
  iq_sel_e          sel       [DEPTH];
  iq_entry_t        slot_entry [NSLOT];
  iq_entry_t        load0;
  iq_entry_t        load1;
  cdb_t [CDB_N-1:0] cdb;

  // Pack flat CDB and dispatch ports into entry-shaped structs.
  always_comb begin
    for (int p = 0; p < int'(CDB_N); p++) begin
      cdb[p].valid = cdb_valid_i[p];
      cdb[p].rid   = cdb_rid_i[p];
      cdb[p].data  = cdb_data_i[p];
    end
    for (int k = 0; k < int'(NSLOT); k++) begin
      slot_entry[k].valid   = 1'b1;
      slot_entry[k].payload = p_payload_i[k];
      for (int s = 0; s < int'(NSRC); s++) begin
        slot_entry[k].src[s].rdy  = p_src_rdy_i[k][s];
        slot_entry[k].src[s].rid  = p_src_rid_i[k][s];
        slot_entry[k].src[s].data = p_src_data_i[k][s];
      end
    end
  end

  assign p_ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(2);

  // Oldest ready entry; a stalled issue stays locked so outputs hold stable.
  always_comb begin
    prio_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (ready_c[i]) prio_idx = IDX_W'(i);
    end
  end

  assign sel_idx      = lock_q ? lock_idx_q : prio_idx;
  assign e_valid_o    = !flush_i && (|ready_c);
  assign e_payload_o  = entries[sel_idx].payload;
  assign e_src_data_o = {entries[sel_idx].src[1].data, entries[sel_idx].src[0].data};

  assign issue    = e_valid_o && e_ready_i;
  assign accept   = p_valid_i && p_ready_o && !flush_i;
  assign n_acc    = accept ? (2'(p_mask_i[0]) + 2'(p_mask_i[1])) : 2'd0;
  assign base_cnt = count_q - CNT_W'(issue);
  assign count_d  = base_cnt + CNT_W'(n_acc);
  assign load0    = p_mask_i[0] ? slot_entry[0] : slot_entry[1];
  assign load1    = slot_entry[1];

  // Compaction first (survivors at or above the issued index shift down),
  // then accepted slots append at the new tail.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      sel[i] = SEL_CLEAR;
      if (CNT_W'(i) < base_cnt)
        sel[i] = (issue && (IDX_W'(i) >= sel_idx)) ? SEL_SHIFT : SEL_HOLD;
      else if ((n_acc != 2'd0) && (CNT_W'(i) == base_cnt))
        sel[i] = SEL_LOAD0;
      else if ((n_acc == 2'd2) && (CNT_W'(i) == base_cnt + CNT_W'(1)))
        sel[i] = SEL_LOAD1;
    end
  end

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_entry
    if (g == int'(DEPTH) - 1) begin : g_last
      assign shift_src[g] = '0;
    end else begin : g_mid
      assign shift_src[g] = entries[g+1];
    end

    wired_iq_entry #(.CDB_N(CDB_N)) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush_i),
      .sel      (sel[g]),
      .shift_in (shift_src[g]),
      .load0    (load0),
      .load1    (load1),
      .cdb      (cdb),
      .entry    (entries[g]),
      .ready_c  (ready_c[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      count_q    <= count_d;
      lock_q     <= e_valid_o && !e_ready_i;
      lock_idx_q <= sel_idx;
    end
  end

endmodule

// File: tb/tb_wired_iq_dispatch.sv
// Bench for wired_iq_dispatch: table-driven dispatch vectors plus directed
// wakeup, fill, ordering, bypass, stall and flush sequences, scoreboarded.
module tb_wired_iq_dispatch;
  import wired_iq_dispatch_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CDB_N = 2;

  logic clk = 1'b0;
  logic rst_n, flush_i, p_valid_i, p_ready_o, e_valid_o, e_ready_i;
  logic [1:0]                      p_mask_i;
  logic [1:0][PAYLOAD_W-1:0]       p_payload_i;
  logic [1:0][1:0][ROB_ID_W-1:0]   p_src_rid_i;
  logic [1:0][1:0]                 p_src_rdy_i;
  logic [1:0][1:0][DATA_W-1:0]     p_src_data_i;
  logic [CDB_N-1:0]                cdb_valid_i;
  logic [CDB_N-1:0][ROB_ID_W-1:0]  cdb_rid_i;
  logic [CDB_N-1:0][DATA_W-1:0]    cdb_data_i;
  logic [PAYLOAD_W-1:0]            e_payload_o;
  logic [1:0][DATA_W-1:0]          e_src_data_o;

  wired_iq_dispatch #(.DEPTH(DEPTH), .CDB_N(CDB_N)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .p_valid_i(p_valid_i), .p_ready_o(p_ready_o), .p_mask_i(p_mask_i),
    .p_payload_i(p_payload_i), .p_src_rid_i(p_src_rid_i),
    .p_src_rdy_i(p_src_rdy_i), .p_src_data_i(p_src_data_i),
    .cdb_valid_i(cdb_valid_i), .cdb_rid_i(cdb_rid_i), .cdb_data_i(cdb_data_i),
    .e_valid_o(e_valid_o), .e_ready_i(e_ready_i),
    .e_payload_o(e_payload_o), .e_src_data_o(e_src_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tag;
    logic        r0, r1;
    logic [5:0]  id0, id1;
    logic [31:0] d0, d1;
  } slot_t;

  typedef struct {
    logic [PAYLOAD_W-1:0] pay;
    logic [31:0]          d0, d1;
  } exp_t;

  typedef struct {
    logic [1:0]  mask;
    slot_t       s0, s1;
    logic        exp_valid;
    logic [31:0] exp_d0;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  function automatic logic [PAYLOAD_W-1:0] mkpay(input logic [7:0] tag);
    return PAYLOAD_W'({tag, 80'h5A5A_0000_0000_0000_C3C3, tag});
  endfunction

  function automatic slot_t mk(input logic [7:0] tag, input logic r0, input logic [5:0] id0,
                               input logic [31:0] d0, input logic r1, input logic [5:0] id1,
                               input logic [31:0] d1);
    slot_t s;
    s.tag = tag; s.r0 = r0; s.id0 = id0; s.d0 = d0; s.r1 = r1; s.id1 = id1; s.d1 = d1;
    return s;
  endfunction

  function automatic exp_t ex(input logic [7:0] tag, input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    e.pay = mkpay(tag); e.d0 = d0; e.d1 = d1;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_pkt(input logic [1:0] m, input slot_t a, input slot_t b);
    p_valid_i = 1'b1;
    p_mask_i  = m;
    p_payload_i[0] = mkpay(a.tag);
    p_payload_i[1] = mkpay(b.tag);
    p_src_rdy_i[0] = {a.r1, a.r0};
    p_src_rdy_i[1] = {b.r1, b.r0};
    p_src_rid_i[0][0] = a.id0; p_src_rid_i[0][1] = a.id1;
    p_src_rid_i[1][0] = b.id0; p_src_rid_i[1][1] = b.id1;
    p_src_data_i[0][0] = a.d0; p_src_data_i[0][1] = a.d1;
    p_src_data_i[1][0] = b.d0; p_src_data_i[1][1] = b.d1;
  endtask

  task automatic idle_pkt();
    p_valid_i = 1'b0;
    p_mask_i  = 2'b00;
  endtask

  task automatic cdb_set(input int port, input logic [5:0] rid, input logic [31:0] data);
    cdb_valid_i[port] = 1'b1;
    cdb_rid_i[port]   = rid;
    cdb_data_i[port]  = data;
  endtask

  task automatic cdb_clr();
    cdb_valid_i = '0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) next();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected issues still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Issue monitor: every accepted issue must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && e_valid_o === 1'b1 && e_ready_i === 1'b1 && flush_i === 1'b0) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL issue_unexpected: got payload %0h, required no issue", e_payload_o);
      end else begin
        mon_e = sb.pop_front();
        if (e_payload_o !== mon_e.pay || e_src_data_o[0] !== mon_e.d0 ||
            e_src_data_o[1] !== mon_e.d1) begin
          fails++;
          $display("FAIL issue_order: got %0h/%0h/%0h, required %0h/%0h/%0h",
                   e_payload_o, e_src_data_o[0], e_src_data_o[1],
                   mon_e.pay, mon_e.d0, mon_e.d1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t  vecs [5];
    slot_t junk;
    slot_t a, b, c, d;

    junk = mk(8'hEE, 1'b1, 6'd0, 32'hBAD, 1'b1, 6'd0, 32'hBAD);
    vecs[0] = '{2'b11, mk(8'h11, 1, 0, 32'h11, 1, 0, 32'h22), mk(8'h12, 1, 0, 32'h33, 1, 0, 32'h44), 1'b1, 32'h11};
    vecs[1] = '{2'b01, mk(8'h21, 1, 0, 32'hA0, 1, 0, 32'hA1), junk, 1'b1, 32'hA0};
    vecs[2] = '{2'b10, junk, mk(8'h31, 1, 0, 32'hB0, 1, 0, 32'hB1), 1'b1, 32'hB0};
    vecs[3] = '{2'b00, junk, junk, 1'b0, 32'h0};
    vecs[4] = '{2'b11, mk(8'h41, 1, 0, 32'hC0, 1, 0, 32'hC1), mk(8'h42, 1, 0, 32'hD0, 1, 0, 32'hD1), 1'b1, 32'hC0};

    rst_n = 1'b0; flush_i = 1'b0; e_ready_i = 1'b1;
    idle_pkt();
    p_payload_i = '0; p_src_rid_i = '0; p_src_rdy_i = '0; p_src_data_i = '0;
    cdb_valid_i = '0; cdb_rid_i = '0; cdb_data_i = '0;
    repeat (3) next();
    mid();
    chk("reset_e_valid", 128'(e_valid_o), 128'(1'b0));
    chk("reset_p_ready", 128'(p_ready_o), 128'(1'b1));
    next();
    rst_n = 1'b1;

    // Table-driven all-ready dispatches.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].mask[0]) sb.push_back(ex(vecs[v].s0.tag, vecs[v].s0.d0, vecs[v].s0.d1));
      if (vecs[v].mask[1]) sb.push_back(ex(vecs[v].s1.tag, vecs[v].s1.d0, vecs[v].s1.d1));
      next();
      drive_pkt(vecs[v].mask, vecs[v].s0, vecs[v].s1);
      next();
      idle_pkt();
      mid();
      chk($sformatf("vec%0d_valid", v), 128'(e_valid_o), 128'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) chk($sformatf("vec%0d_d0", v), 128'(e_src_data_o[0]), 128'(vecs[v].exp_d0));
      if (v == 0) begin
        next();
        mid();
        chk("vec0_slot1_next", 128'(e_src_data_o), 128'({32'h44, 32'h33}));
      end
      wait_drain();
    end

    // Late wakeup from CDB port 1.
    next();
    drive_pkt(2'b01, mk(8'h50, 0, 6'd5, 32'h0, 1, 6'd0, 32'h77), junk);
    next();
    idle_pkt();
    mid();
    chk("wake_wait0", 128'(e_valid_o), 128'(1'b0));
    next();
    mid();
    chk("wake_wait1", 128'(e_valid_o), 128'(1'b0));
    next();
    cdb_set(1, 6'd5, 32'hDEADBEEF);
    sb.push_back(ex(8'h50, 32'hDEADBEEF, 32'h77));
    mid();
    chk("wake_bcast_cycle", 128'(e_valid_o), 128'(1'b0));
    next();
    cdb_clr();
    mid();
    chk("wake_valid", 128'(e_valid_o), 128'(1'b1));
    chk("wake_data", 128'(e_src_data_o[0]), 128'(32'hDEADBEEF));
    wait_drain();

    // Two ports hit the same rid: port 0 wins; the already-ready src1 keeps its data.
    next();
    drive_pkt(2'b01, mk(8'h51, 0, 6'd3, 32'h0, 1, 6'd3, 32'h78), junk);
    next();
    idle_pkt();
    next();
    cdb_set(0, 6'd3, 32'hAAAA);
    cdb_set(1, 6'd3, 32'hBBBB);
    sb.push_back(ex(8'h51, 32'hAAAA, 32'h78));
    next();
    cdb_clr();
    mid();
    chk("prio_valid", 128'(e_valid_o), 128'(1'b1));
    wait_drain();

    // Fill with unready entries; p_ready tracks the registered count.
    for (int k = 0; k < 4; k++) begin
      mid();
      chk($sformatf("fill_ready%0d", k), 128'(p_ready_o), 128'(1'b1));
      next();
      drive_pkt(2'b11, mk(8'(8'h60 + 2 * k), 0, 6'(10 + 2 * k), 0, 1, 0, 32'(k)),
                       mk(8'(8'h61 + 2 * k), 0, 6'(11 + 2 * k), 0, 1, 0, 32'(k)));
      next();
      idle_pkt();
    end
    mid();
    chk("full_ready", 128'(p_ready_o), 128'(1'b0));
    chk("full_valid", 128'(e_valid_o), 128'(1'b0));
    next();
    drive_pkt(2'b11, mk(8'hE1, 1, 0, 32'hE1, 1, 0, 32'hE1), mk(8'hE2, 1, 0, 32'hE2, 1, 0, 32'hE2));
    next();
    idle_pkt();
    cdb_set(0, 6'd10, 32'h1000);
    sb.push_back(ex(8'h60, 32'h1000, 32'h0));
    next();
    cdb_clr();
    mid();
    chk("c8_issue_valid", 128'(e_valid_o), 128'(1'b1));
    chk("c8_issue_ready", 128'(p_ready_o), 128'(1'b0));
    next();
    cdb_set(0, 6'd11, 32'h1001);
    sb.push_back(ex(8'h61, 32'h1001, 32'h0));
    mid();
    chk("c7_ready", 128'(p_ready_o), 128'(1'b0));
    next();
    cdb_clr();
    next();
    mid();
    chk("c6_ready", 128'(p_ready_o), 128'(1'b1));
    // Back-to-back wakes: each woken entry shifts down while the previous issues.
    for (int j = 0; j < 6; j++) begin
      next();
      cdb_clr();
      cdb_set(j % 2, 6'(12 + j), 32'(32'h1002 + j));
      sb.push_back(ex(8'(8'h62 + j), 32'(32'h1002 + j), 32'((j + 2) / 2)));
    end
    next();
    cdb_clr();
    wait_drain();

    // Younger ready entries overtake older unready ones; order survives compaction.
    a = mk(8'h70, 0, 6'd20, 0, 1, 0, 32'h1);
    b = mk(8'h71, 1, 0, 32'h71, 1, 0, 32'h171);
    c = mk(8'h72, 0, 6'd21, 0, 1, 0, 32'h2);
    d = mk(8'h73, 1, 0, 32'h73, 1, 0, 32'h173);
    sb.push_back(ex(8'h71, 32'h71, 32'h171));
    sb.push_back(ex(8'h73, 32'h73, 32'h173));
    next();
    drive_pkt(2'b11, a, b);
    next();
    drive_pkt(2'b11, c, d);
    next();
    idle_pkt();
    wait_drain();
    next();
    cdb_set(0, 6'd20, 32'hA0A0);
    cdb_set(1, 6'd21, 32'hC0C0);
    sb.push_back(ex(8'h70, 32'hA0A0, 32'h1));
    sb.push_back(ex(8'h72, 32'hC0C0, 32'h2));
    next();
    cdb_clr();
    mid();
    chk("age_oldest_first", 128'(e_payload_o), 128'(mkpay(8'h70)));
    wait_drain();

    // Wakeup lands on an entry in the same cycle it shifts down.
    sb.push_back(ex(8'h80, 32'h80, 32'h180));
    sb.push_back(ex(8'h81, 32'h4040, 32'h181));
    next();
    drive_pkt(2'b11, mk(8'h80, 1, 0, 32'h80, 1, 0, 32'h180), mk(8'h81, 0, 6'd40, 0, 1, 0, 32'h181));
    next();
    idle_pkt();
    cdb_set(0, 6'd40, 32'h4040);
    next();
    cdb_clr();
    mid();
    chk("shift_wake_valid", 128'(e_valid_o), 128'(1'b1));
    chk("shift_wake_pay", 128'(e_payload_o), 128'(mkpay(8'h81)));
    wait_drain();

    // Same-cycle CDB bypass at dispatch.
    sb.push_back(ex(8'h90, 32'hCAFE0009, 32'h190));
    next();
    drive_pkt(2'b01, mk(8'h90, 0, 6'd9, 0, 1, 0, 32'h190), junk);
    cdb_set(0, 6'd9, 32'hCAFE0009);
    next();
    idle_pkt();
    cdb_clr();
    mid();
    chk("bypass_valid", 128'(e_valid_o), 128'(1'b1));
    chk("bypass_data", 128'(e_src_data_o[0]), 128'(32'hCAFE0009));
    wait_drain();

    // Stalled issue holds even when an older entry wakes; then flush.
    next();
    e_ready_i = 1'b0;
    drive_pkt(2'b11, mk(8'hA0, 0, 6'd50, 0, 1, 0, 32'h1A0), mk(8'hA1, 1, 0, 32'h2A1, 1, 0, 32'h3A1));
    next();
    idle_pkt();
    mid();
    chk("stall_pay0", 128'(e_payload_o), 128'(mkpay(8'hA1)));
    next();
    drive_pkt(2'b11, mk(8'hA2, 1, 0, 32'hA2, 1, 0, 32'hA2), mk(8'hA3, 1, 0, 32'hA3, 1, 0, 32'hA3));
    next();
    idle_pkt();
    mid();
    chk("stall_pay1", 128'(e_payload_o), 128'(mkpay(8'hA1)));
    next();
    cdb_set(0, 6'd50, 32'h5050);
    next();
    cdb_clr();
    mid();
    chk("stall_hold_valid", 128'(e_valid_o), 128'(1'b1));
    chk("stall_hold_pay", 128'(e_payload_o), 128'(mkpay(8'hA1)));
    next();
    flush_i = 1'b1;
    drive_pkt(2'b11, mk(8'hF1, 1, 0, 32'hF1, 1, 0, 32'hF1), mk(8'hF2, 1, 0, 32'hF2, 1, 0, 32'hF2));
    mid();
    chk("flush_cycle_valid", 128'(e_valid_o), 128'(1'b0));
    next();
    flush_i = 1'b0;
    idle_pkt();
    mid();
    chk("post_flush_valid", 128'(e_valid_o), 128'(1'b0));
    chk("post_flush_ready", 128'(p_ready_o), 128'(1'b1));
    next();
    e_ready_i = 1'b1;
    repeat (2) next();
    mid();
    chk("post_flush_empty", 128'(e_valid_o), 128'(1'b0));

    // Normal operation after flush.
    sb.push_back(ex(8'hB0, 32'hB00, 32'hB01));
    next();
    drive_pkt(2'b01, mk(8'hB0, 1, 0, 32'hB00, 1, 0, 32'hB01), junk);
    next();
    idle_pkt();
    mid();
    chk("after_flush_issue", 128'(e_valid_o), 128'(1'b1));
    wait_drain();

    repeat (2) next();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
